imem_fetch_ctrl: RTL

Controller that owns the single-port, byte-wide instruction memory (little-endian, 4 bytes per instruction) and shares it between two requesters. The boot loader streams program bytes in, and the fetch side requests an instruction by PC. For each fetch, the block sequences four byte reads and returns an assembled 32-bit instruction over a valid/ready handshake. It sits between the PC register / decode stage and the instruction RAM.

---
 rtl/imem_fetch_ctrl_pkg.sv | 6 +
 rtl/imem_fetch_ctrl_if.sv | 34 +++
 rtl/imem_fetch_ctrl_asm.sv | 23 ++
 rtl/imem_fetch_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_ctrl_pkg: shared types and constants for the instruction memory fetch controller
package imem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FETCH, RESP} state_t;
  localparam int BYTES_PER_INSTR = 4;
  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0013;
endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: fetch, response, loader and byte-memory signals of the fetch controller
// slave: controller view (takes requests, drives responses and the memory port)
// master: requester/environment view (PC stage, decode, boot loader, RAM)
interface imem_fetch_ctrl_if #(parameter int ADDR_W = 7);
  logic              pc_req_valid;
  logic              pc_req_ready;
  logic [31:0]       pc_req_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_fault;
  logic              ld_valid;
  logic              ld_ready;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              prog_loaded;
  logic              ld_wrap;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  modport slave (
    input  pc_req_valid, pc_req_addr, instr_ready, ld_valid, ld_data, ld_last, mem_rdata,
    output pc_req_ready, instr_valid, instr, instr_pc, instr_fault, ld_ready,
           prog_loaded, ld_wrap, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output pc_req_valid, pc_req_addr, instr_ready, ld_valid, ld_data, ld_last, mem_rdata,
    input  pc_req_ready, instr_valid, instr, instr_pc, instr_fault, ld_ready,
           prog_loaded, ld_wrap, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_fetch_ctrl_asm.sv
// instr_byte_assembler: holds the response word and inserts captured read bytes by index
// load_i/load_val_i: preset the word (NOP on a fault, zero on a fetch)
// cap_i/idx_i/byte_i: write byte_i into byte lane idx_i; word_o: held word
module instr_byte_assembler #(
  parameter int BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic [8*BYTES-1:0]         load_val_i,
  input  logic                       cap_i,
  input  logic [$clog2(BYTES)-1:0]   idx_i,
  input  logic [7:0]                 byte_i,
  output logic [8*BYTES-1:0]         word_o
);
  logic [8*BYTES-1:0] word_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_q <= '0;
    else if (load_i) word_q <= load_val_i;
    else if (cap_i) word_q[8*idx_i +: 8] <= byte_i;
  end
  assign word_o = word_q;
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: arbitrates a byte-wide instruction RAM between a boot loader and a 32-bit fetch port
// clk/rst: clock, async active-high reset
// bus (slave): pc_req_* fetch request, instr_* response, ld_* loader stream, mem_* RAM port
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 7,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input logic              clk,
  input logic              rst,
  imem_fetch_ctrl_if.slave bus
);
  state_t            state_q;
  logic [2:0]        k_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [31:0]       pc_q;
  logic              fault_q, valid_q, loaded_q, wrap_q;
  logic              ld_fire, rd_fire, req_fire, req_fault, cap;
  logic [31:0]       word;
  // Combinational outputs are gated by rst so they drop the instant reset is asserted.
  assign bus.ld_ready     = !rst && (state_q == IDLE || state_q == LOAD);
  assign bus.pc_req_ready = !rst && state_q == IDLE && !bus.ld_valid;
  assign ld_fire          = bus.ld_ready && bus.ld_valid;
  assign req_fire         = bus.pc_req_ready && bus.pc_req_valid;
  assign req_fault        = (bus.pc_req_addr[1:0] != 2'b0) || ((bus.pc_req_addr >> ADDR_W) != 32'd0);
  assign rd_fire          = !rst && state_q == FETCH && k_q < 3'(BYTES_PER_INSTR);
  // Byte k-1 arrives one cycle after its read, so capture lags the address by one step.
  assign cap              = state_q == FETCH && k_q != 3'd0;
  assign bus.mem_en       = ld_fire || rd_fire;
  assign bus.mem_we       = ld_fire;
  assign bus.mem_addr     = ld_fire ? ptr_q : pc_q[ADDR_W-1:0] + ADDR_W'(k_q);
  assign bus.mem_wdata    = bus.ld_data;
  assign bus.instr_valid  = valid_q;
  assign bus.instr        = word;
  assign bus.instr_pc     = pc_q;
  assign bus.instr_fault  = fault_q;
  assign bus.prog_loaded  = loaded_q;
  assign bus.ld_wrap      = wrap_q;
  instr_byte_assembler #(.BYTES(BYTES_PER_INSTR)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .load_i     (req_fire),
    .load_val_i (req_fault ? NOP_INSTR : 32'd0),
    .cap_i      (cap),
    .idx_i      (2'(k_q - 3'd1)),
    .byte_i     (bus.mem_rdata),
    .word_o     (word)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      ptr_q    <= '0;
      pc_q     <= '0;
      fault_q  <= 1'b0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      if (ld_fire) begin
        ptr_q   <= bus.ld_last ? '0 : ptr_q + 1'b1;
        wrap_q  <= wrap_q || (!bus.ld_last && &ptr_q);
        loaded_q <= loaded_q || bus.ld_last;
        state_q <= bus.ld_last ? IDLE : LOAD;
      end
      case (state_q)
        IDLE: if (req_fire) begin
          pc_q    <= bus.pc_req_addr;
          fault_q <= req_fault;
          valid_q <= req_fault;
          k_q     <= '0;
          state_q <= req_fault ? RESP : FETCH;
        end
        FETCH: begin
          k_q <= k_q + 3'd1;
          if (k_q == 3'(BYTES_PER_INSTR)) begin
            valid_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: if (bus.instr_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule
